// File: rtl/ysyx_22051145_ifu_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM encoding,
// reset fetch address, instruction width and the sequential-pc helper.
package ysyx_22051145_ifu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } ifu_state_t;

  localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;
  localparam int          IFU_INST_W   = 32;

  // Sequential fetch address; wraps naturally modulo 2^64.
  function automatic logic [63:0] pc_inc(input logic [63:0] pc);
    return pc + 64'd4;
  endfunction

endpackage

// File: rtl/ysyx_22051145_pc_gen.sv
// Fetch program counter: reset / redirect / sequential / hold selection.
module ysyx_22051145_pc_gen
  import ysyx_22051145_ifu_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] load_addr,
  input  logic        advance,
  output logic [63:0] pc
);

  logic [63:0] pc_r;
  logic [63:0] pc_next_s;

  // Next-pc mux; a redirect outranks sequential advance.
  always_comb begin
    pc_next_s = pc_r;
    if (load) begin
      pc_next_s = load_addr;
    end else if (advance) begin
      pc_next_s = pc_inc(pc_r);
    end else begin
      pc_next_s = pc_r;
    end
  end

  // PC register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/ysyx_22051145_ifu_ctrl.sv
// Single-outstanding instruction fetch controller with redirect/drop handling.
// Optional misaligned-redirect trap enabled by YSYX_22051145_FETCH_MISALIGN_EN.
module ysyx_22051145_ifu_ctrl
  import ysyx_22051145_ifu_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC = IFU_RESET_PC,
  parameter int          INST_W   = IFU_INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_flag,
  input  logic [63:0]       jump_addr,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [63:0]       imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [63:0]       inst_pc
`ifdef YSYX_22051145_FETCH_MISALIGN_EN
  ,
  output logic              misalign
`endif
);

  ifu_state_t        state_r;
  logic              drop_r;
  logic              req_valid_r;
  logic              hold_r;
  logic [INST_W-1:0] inst_data_r;
  logic [63:0]       inst_pc_r;
  logic              misalign_r;
  logic [63:0]       pc_s;
  logic              bad_jump_s;
  logic              redirect_s;
  logic              advance_s;

  // Redirect qualification; IDLE ignores jump_flag entirely.
  always_comb begin
    bad_jump_s = 1'b0;
`ifdef YSYX_22051145_FETCH_MISALIGN_EN
    if (jump_flag && (jump_addr[1:0] != 2'b00)) begin
      bad_jump_s = 1'b1;
    end else begin
      bad_jump_s = 1'b0;
    end
`endif
    redirect_s = jump_flag && (state_r != IDLE) && !bad_jump_s;
    advance_s  = (state_r == HOLD) && inst_ready && !jump_flag;
  end

  ysyx_22051145_pc_gen #(
    .RESET_PC(RESET_PC)
  ) u_pc_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (redirect_s),
    .load_addr(jump_addr),
    .advance  (advance_s),
    .pc       (pc_s)
  );

  // Fetch FSM; a redirect in any active state outranks the normal flow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      drop_r      <= 1'b0;
      req_valid_r <= 1'b0;
      hold_r      <= 1'b0;
      inst_data_r <= '0;
      inst_pc_r   <= 64'd0;
      misalign_r  <= 1'b0;
    end else if (jump_flag && (state_r != IDLE)) begin
      if (bad_jump_s) begin
        state_r     <= IDLE;
        drop_r      <= 1'b0;
        req_valid_r <= 1'b0;
        hold_r      <= 1'b0;
        misalign_r  <= 1'b1;
      end else begin
        case (state_r)
          REQ: begin
            if (imem_req_ready) begin
              state_r     <= WAIT;
              drop_r      <= 1'b1;
              req_valid_r <= 1'b0;
            end else begin
              req_valid_r <= 1'b1;
            end
          end
          WAIT: begin
            // A response arriving alongside the redirect is already stale.
            if (imem_resp_valid) begin
              state_r     <= REQ;
              drop_r      <= 1'b0;
              req_valid_r <= 1'b1;
            end else begin
              drop_r <= 1'b1;
            end
          end
          HOLD: begin
            state_r     <= REQ;
            hold_r      <= 1'b0;
            req_valid_r <= 1'b1;
          end
          default: begin
            state_r     <= IDLE;
            req_valid_r <= 1'b0;
            hold_r      <= 1'b0;
          end
        endcase
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (!misalign_r) begin
            state_r     <= REQ;
            req_valid_r <= 1'b1;
          end else begin
            req_valid_r <= 1'b0;
          end
        end
        REQ: begin
          if (imem_req_ready) begin
            state_r     <= WAIT;
            req_valid_r <= 1'b0;
          end else begin
            req_valid_r <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_resp_valid && drop_r) begin
            state_r     <= REQ;
            drop_r      <= 1'b0;
            req_valid_r <= 1'b1;
          end else if (imem_resp_valid) begin
            state_r     <= HOLD;
            hold_r      <= 1'b1;
            inst_data_r <= imem_resp_data;
            inst_pc_r   <= pc_s;
          end else begin
            req_valid_r <= 1'b0;
          end
        end
        HOLD: begin
          if (inst_ready) begin
            state_r     <= REQ;
            hold_r      <= 1'b0;
            req_valid_r <= 1'b1;
          end else begin
            hold_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_valid_r <= 1'b0;
          hold_r      <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = req_valid_r;
  assign imem_req_addr  = pc_s;
  assign inst_valid     = hold_r && !jump_flag;
  assign inst_data      = inst_data_r;
  assign inst_pc        = inst_pc_r;
`ifdef YSYX_22051145_FETCH_MISALIGN_EN
  assign misalign       = misalign_r;
`endif

endmodule
